// File: rtl/vec_acc_unit.sv
// ============================================================================
//  Module  : vec_acc_unit
//  Brief   : Element-wise vector ADD/SUB/MUL/DOT engine over 256-word windows,
//            two-stage pipeline, registered result window.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_acc_unit #(
  parameter int NUM_ELEMS = 256,
  parameter int IDX_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [IDX_WIDTH-1:0] len_i,
  input  logic [3:0][7:0]      acc_a_i   [NUM_ELEMS],
  input  logic [3:0][7:0]      acc_b_i   [NUM_ELEMS],
  output logic [3:0][7:0]      acc_res_o [NUM_ELEMS],
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int                   c_AW      = $clog2(NUM_ELEMS);
  localparam logic [IDX_WIDTH-1:0] c_MAX_LEN = IDX_WIDTH'(NUM_ELEMS);
  localparam logic [1:0]           c_OP_ADD  = 2'd0;
  localparam logic [1:0]           c_OP_SUB  = 2'd1;
  localparam logic [1:0]           c_OP_MUL  = 2'd2;
  localparam logic [1:0]           c_OP_DOT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [1:0]           r_op;
  logic [IDX_WIDTH-1:0] r_len;
  logic [IDX_WIDTH-1:0] r_idx;
  logic [IDX_WIDTH-1:0] w_len_clamped;
  logic                 w_accept;
  logic                 w_issue;

  logic                 r_s1_valid;
  logic [31:0]          r_s1_a;
  logic [31:0]          r_s1_b;
  logic [c_AW-1:0]      r_s1_idx;

  logic [31:0]          r_acc;
  logic [31:0]          w_prod;
  logic [31:0]          w_dot;

  assign w_len_clamped = (len_i > c_MAX_LEN) ? c_MAX_LEN : len_i;
  assign w_accept      = (r_state == S_IDLE) && start_i;
  assign w_prod        = r_s1_a * r_s1_b;
  assign w_dot         = r_acc + w_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A zero-length request skips RUN so done still lands at cycle len+2.
        if (start_i) begin
          w_state_next = (w_len_clamped == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        busy_o  = 1'b1;
        w_issue = 1'b1;
        if (r_idx == r_len - 1'b1) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy_o       = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        busy_o       = 1'b1;
        done_o       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= 2'd0;
      r_len <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_op  <= op_i;
      r_len <= w_len_clamped;
      r_idx <= '0;
    end else if (w_issue) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Stage 1: operand capture straight from the mirrored RAM windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_idx   <= '0;
    end else begin
      r_s1_valid <= w_issue;
      if (w_issue) begin
        r_s1_a   <= acc_a_i[r_idx[c_AW-1:0]];
        r_s1_b   <= acc_b_i[r_idx[c_AW-1:0]];
        r_s1_idx <= r_idx[c_AW-1:0];
      end
    end
  end

  // Stage 2: compute and retire into the result window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      for (int k = 0; k < NUM_ELEMS; k++) begin
        acc_res_o[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_acc <= '0;
      end
      if (r_s1_valid) begin
        case (r_op)
          c_OP_ADD: acc_res_o[r_s1_idx] <= r_s1_a + r_s1_b;
          c_OP_SUB: acc_res_o[r_s1_idx] <= r_s1_a - r_s1_b;
          c_OP_MUL: acc_res_o[r_s1_idx] <= w_prod;
          c_OP_DOT: begin
            r_acc        <= w_dot;
            acc_res_o[0] <= w_dot;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vec_acc_unit.sv
// ============================================================================
//  Module  : tb_vec_acc_unit
//  Brief   : Directed self-checking bench for vec_acc_unit.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_acc_unit;

  logic            clk;
  logic            rst;
  logic            start_i;
  logic [1:0]      op_i;
  logic [8:0]      len_i;
  logic [3:0][7:0] acc_a [256];
  logic [3:0][7:0] acc_b [256];
  logic [3:0][7:0] acc_res [256];
  logic            busy_o;
  logic            done_o;

  int tests;
  int failed;

  vec_acc_unit #(.NUM_ELEMS(256), .IDX_WIDTH(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .op_i      (op_i),
    .len_i     (len_i),
    .acc_a_i   (acc_a),
    .acc_b_i   (acc_b),
    .acc_res_o (acc_res),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one start in cycle 0 and observes ncyc following cycles.
  task automatic run_op(input logic [1:0] op, input logic [8:0] len, input int ncyc,
                        input int p1, input int p2, input bit tog,
                        output int dcyc, output int dcnt, output int bcnt, output int blast);
    dcyc = -1; dcnt = 0; bcnt = 0; blast = 0;
    @(posedge clk); #1;
    op_i = op; len_i = len; start_i = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start_i = (c == p1) || (c == p2);
      op_i    = (tog && c >= 2) ? ~op : op;
      len_i   = (tog && c >= 2) ? 9'd1 : len;
      @(negedge clk);
      if (done_o) begin dcnt++; if (dcyc < 0) dcyc = c; end
      if (busy_o) begin bcnt++; blast = c; end
    end
    start_i = 1'b0;
  endtask

  task automatic set_ab(input int i, input logic [31:0] a, input logic [31:0] b);
    acc_a[i] = a;
    acc_b[i] = b;
  endtask

  task automatic test_reset;
    int nz;
    rst = 1'b1; start_i = 1'b0; op_i = 2'd0; len_i = '0;
    for (int i = 0; i < 256; i++) begin acc_a[i] = '0; acc_b[i] = '0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (busy_o !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", busy_o); end
    tests++; if (done_o !== 1'b0) begin failed++; $display("FAIL reset_done got %b want 0", done_o); end
    nz = 0;
    for (int i = 0; i < 256; i++) if (acc_res[i] !== 32'h0) nz++;
    tests++; if (nz != 0) begin failed++; $display("FAIL reset_res nonzero words got %0d want 0", nz); end
  endtask

  task automatic test_add;
    int dcyc, dcnt, bcnt, blast, nz;
    set_ab(0, 32'd1, 32'd10); set_ab(1, 32'd2, 32'd20);
    set_ab(2, 32'd3, 32'd30); set_ab(3, 32'hFFFF_FFFF, 32'd1);
    run_op(2'd0, 9'd4, 10, 0, 0, 1'b0, dcyc, dcnt, bcnt, blast);
    tests++; if (acc_res[0] !== 32'd11) begin failed++; $display("FAIL add_res0 got %h want %h", acc_res[0], 32'd11); end
    tests++; if (acc_res[1] !== 32'd22) begin failed++; $display("FAIL add_res1 got %h want %h", acc_res[1], 32'd22); end
    tests++; if (acc_res[2] !== 32'd33) begin failed++; $display("FAIL add_res2 got %h want %h", acc_res[2], 32'd33); end
    tests++; if (acc_res[3] !== 32'd0)  begin failed++; $display("FAIL add_res3 got %h want 0", acc_res[3]); end
    nz = 0;
    for (int i = 4; i < 256; i++) if (acc_res[i] !== 32'h0) nz++;
    tests++; if (nz != 0) begin failed++; $display("FAIL add_tail nonzero words got %0d want 0", nz); end
    tests++; if (dcyc != 6 || dcnt != 1) begin failed++; $display("FAIL add_done cycle %0d count %0d want cycle 6 count 1", dcyc, dcnt); end
    tests++; if (bcnt != 6 || blast != 6) begin failed++; $display("FAIL add_busy count %0d last %0d want 6/6", bcnt, blast); end
  endtask

  task automatic test_sub_mul;
    int dcyc, dcnt, bcnt, blast;
    set_ab(0, 32'd5, 32'd7);
    run_op(2'd1, 9'd1, 6, 0, 0, 1'b0, dcyc, dcnt, bcnt, blast);
    tests++; if (acc_res[0] !== 32'hFFFF_FFFE) begin failed++; $display("FAIL sub_res0 got %h want fffffffe", acc_res[0]); end
    tests++; if (acc_res[1] !== 32'd22) begin failed++; $display("FAIL sub_res1_kept got %h want %h", acc_res[1], 32'd22); end
    tests++; if (dcyc != 3) begin failed++; $display("FAIL sub_done cycle %0d want 3", dcyc); end
    set_ab(0, 32'h0001_0000, 32'h0001_0000); set_ab(1, 32'd3, 32'd7);
    run_op(2'd2, 9'd2, 7, 0, 0, 1'b0, dcyc, dcnt, bcnt, blast);
    tests++; if (acc_res[0] !== 32'd0)  begin failed++; $display("FAIL mul_res0 got %h want 0", acc_res[0]); end
    tests++; if (acc_res[1] !== 32'd21) begin failed++; $display("FAIL mul_res1 got %h want %h", acc_res[1], 32'd21); end
    tests++; if (acc_res[2] !== 32'd33) begin failed++; $display("FAIL mul_res2_kept got %h want %h", acc_res[2], 32'd33); end
  endtask

  task automatic test_dot;
    int dcyc, dcnt, bcnt, blast;
    for (int i = 0; i < 256; i++) set_ab(i, 32'(i), 32'd1);
    run_op(2'd3, 9'd256, 262, 0, 0, 1'b0, dcyc, dcnt, bcnt, blast);
    tests++; if (acc_res[0] !== 32'd32640) begin failed++; $display("FAIL dot_res0 got %0d want 32640", acc_res[0]); end
    tests++; if (acc_res[1] !== 32'd21 || acc_res[2] !== 32'd33) begin
      failed++; $display("FAIL dot_others got %h %h want %h %h", acc_res[1], acc_res[2], 32'd21, 32'd33); end
    tests++; if (dcyc != 258 || dcnt != 1) begin failed++; $display("FAIL dot_done cycle %0d count %0d want 258/1", dcyc, dcnt); end
    run_op(2'd3, 9'd300, 262, 0, 0, 1'b0, dcyc, dcnt, bcnt, blast);
    tests++; if (acc_res[0] !== 32'd32640) begin failed++; $display("FAIL dot_clamp_res0 got %0d want 32640", acc_res[0]); end
    tests++; if (dcyc != 258 || bcnt != 258) begin failed++; $display("FAIL dot_clamp_timing done %0d busy %0d want 258/258", dcyc, bcnt); end
  endtask

  task automatic test_len_zero;
    int dcyc, dcnt, bcnt, blast;
    set_ab(0, 32'd1, 32'd10); set_ab(1, 32'd2, 32'd20);
    set_ab(2, 32'd3, 32'd30); set_ab(3, 32'hFFFF_FFFF, 32'd1);
    run_op(2'd0, 9'd4, 8, 0, 0, 1'b0, dcyc, dcnt, bcnt, blast);
    tests++; if (acc_res[0] !== 32'd11) begin failed++; $display("FAIL len0_pre_res0 got %h want %h", acc_res[0], 32'd11); end
    set_ab(0, 32'd100, 32'd100);
    run_op(2'd0, 9'd0, 5, 0, 0, 1'b0, dcyc, dcnt, bcnt, blast);
    tests++; if (acc_res[0] !== 32'd11) begin failed++; $display("FAIL len0_res0 got %h want %h", acc_res[0], 32'd11); end
    tests++; if (dcyc != 2 || dcnt != 1 || bcnt != 2) begin
      failed++; $display("FAIL len0_timing done %0d count %0d busy %0d want 2/1/2", dcyc, dcnt, bcnt); end
  endtask

  task automatic test_back_to_back;
    int dcyc, dcnt, bcnt, blast;
    set_ab(0, 32'd100, 32'd1); set_ab(1, 32'd200, 32'd2);
    set_ab(2, 32'd300, 32'd3); set_ab(3, 32'd400, 32'd4);
    run_op(2'd1, 9'd4, 10, 3, 6, 1'b1, dcyc, dcnt, bcnt, blast);
    tests++; if (dcnt != 1 || dcyc != 6) begin failed++; $display("FAIL b2b_done count %0d cycle %0d want 1/6", dcnt, dcyc); end
    tests++; if (acc_res[0] !== 32'd99 || acc_res[1] !== 32'd198 || acc_res[2] !== 32'd297 || acc_res[3] !== 32'd396) begin
      failed++; $display("FAIL b2b_res got %0d %0d %0d %0d want 99 198 297 396",
                         acc_res[0], acc_res[1], acc_res[2], acc_res[3]); end
  endtask

  task automatic test_reset_midop;
    int nz, dcnt, dcyc, bcnt, blast;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) set_ab(i, 32'd5, 32'd6);
    @(posedge clk); #1;
    op_i = 2'd0; len_i = 9'd8; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    tests++; if (busy_o !== 1'b0) begin failed++; $display("FAIL rst_mid_busy got %b want 0", busy_o); end
    nz = 0;
    for (int i = 0; i < 256; i++) if (acc_res[i] !== 32'h0) nz++;
    tests++; if (nz != 0) begin failed++; $display("FAIL rst_mid_res nonzero words got %0d want 0", nz); end
    @(posedge clk); #1 rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin @(negedge clk); if (done_o) dcnt++; end
    tests++; if (dcnt != 0) begin failed++; $display("FAIL rst_mid_done pulses got %0d want 0", dcnt); end
    for (int i = 0; i < 8; i++) set_ab(i, 32'(i + 1), 32'(2 * i));
    run_op(2'd0, 9'd8, 14, 0, 0, 1'b0, dcyc, dcnt, bcnt, blast);
    tests++; if (dcyc != 10 || dcnt != 1) begin failed++; $display("FAIL rst_after_done cycle %0d count %0d want 10/1", dcyc, dcnt); end
    nz = 0;
    for (int i = 0; i < 8; i++) begin
      exp = 32'(3 * i + 1);
      if (acc_res[i] !== exp) nz++;
    end
    tests++; if (nz != 0) begin failed++; $display("FAIL rst_after_res wrong words got %0d want 0", nz); end
  endtask

  initial begin
    tests = 0; failed = 0;
    test_reset();
    test_add();
    test_sub_mul();
    test_dot();
    test_len_zero();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
